// File: rtl/riscv_tb_pkg.sv
// rtl/riscv_tb_pkg.sv - shared state encoding, fail codes and table entry layout for the checker
package riscv_tb_pkg;

  localparam int NUM_TEST_DEF = 17;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_SKIP     = 2'd2;
  localparam logic [1:0] FC_HALT     = 2'd3;

  typedef struct packed {
    logic [31:0] num_inst;
    logic [31:0] ans;
  } entry_t;

endpackage

// File: rtl/chk_table.sv
// rtl/chk_table.sv - checkpoint table: one sync write port, one combinational read port, no reset
module chk_table #(
  parameter int NUM_TEST = 17,
  parameter int IDX_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [63:0]      i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [63:0]      o_rdata
);

  logic [63:0] r_mem [NUM_TEST];

  // Contents survive reset so a re-run needs only START.
  always_ff @(posedge i_clk) begin
    if (i_we && (int'(i_waddr) < NUM_TEST)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (int'(i_raddr) < NUM_TEST) ? r_mem[i_raddr] : 64'd0;

endmodule

// File: rtl/riscv_test_checker.sv
// rtl/riscv_test_checker.sv - walks a checkpoint table against the core's retired count and output port
module riscv_test_checker
  import riscv_tb_pkg::*;
#(
  parameter int NUM_TEST = NUM_TEST_DEF,
  parameter int IDX_W    = 5
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             TBL_WE,
  input  logic [IDX_W-1:0] TBL_ADDR,
  input  logic [31:0]      TBL_NUM_INST,
  input  logic [31:0]      TBL_ANS,
  input  logic             START,
  input  logic [31:0]      NUM_INST,
  input  logic [31:0]      OUTPUT_PORT,
  input  logic             HALT,
  output logic             DONE,
  output logic             PASSED,
  output logic             FAILED,
  output logic [1:0]       FAIL_CODE,
  output logic [IDX_W-1:0] FAIL_IDX,
  output logic [31:0]      FAIL_OBS,
  output logic [IDX_W:0]   PASS_CNT,
  output logic [31:0]      CYCLE
);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             r_done;
  logic             r_passed;
  logic             r_failed;
  logic [1:0]       r_fail_code;
  logic [IDX_W-1:0] r_fail_idx;
  logic [31:0]      r_fail_obs;
  logic [IDX_W:0]   r_pass_cnt;
  logic [31:0]      r_cycle;

  logic       w_tbl_we;
  entry_t     w_entry;
  logic       w_match;
  logic       w_ans_ok;
  logic       w_skip;
  logic       w_last;
  logic [1:0] w_fail_code;

  assign w_tbl_we = TBL_WE && (r_state == ST_LOAD);

  chk_table #(
    .NUM_TEST (NUM_TEST),
    .IDX_W    (IDX_W)
  ) u_table (
    .i_clk   (CLK),
    .i_we    (w_tbl_we),
    .i_waddr (TBL_ADDR),
    .i_wdata ({TBL_NUM_INST, TBL_ANS}),
    .i_raddr (r_ptr),
    .o_rdata (w_entry)
  );

  assign w_match  = (NUM_INST == w_entry.num_inst);
  assign w_ans_ok = (OUTPUT_PORT == w_entry.ans);
  assign w_skip   = (NUM_INST > w_entry.num_inst);
  assign w_last   = (int'(r_ptr) == NUM_TEST - 1);

  // Mismatch and skip outrank a coincident halt.
  always_comb begin
    w_fail_code = FC_NONE;
    if (w_match && !w_ans_ok) begin
      w_fail_code = FC_MISMATCH;
    end else if (w_skip) begin
      w_fail_code = FC_SKIP;
    end else if (!w_match && HALT) begin
      w_fail_code = FC_HALT;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= ST_LOAD;
      r_ptr       <= '0;
      r_done      <= 1'b0;
      r_passed    <= 1'b0;
      r_failed    <= 1'b0;
      r_fail_code <= FC_NONE;
      r_fail_idx  <= '0;
      r_fail_obs  <= '0;
      r_pass_cnt  <= '0;
      r_cycle     <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (START) begin
            r_state    <= ST_RUN;
            r_ptr      <= '0;
            r_pass_cnt <= '0;
            r_cycle    <= '0;
          end
        end
        ST_RUN: begin
          if (r_cycle != 32'hFFFF_FFFF) begin
            r_cycle <= r_cycle + 32'd1;
          end
          if (w_match && w_ans_ok) begin
            r_ptr      <= r_ptr + IDX_W'(1);
            r_pass_cnt <= r_pass_cnt + (IDX_W + 1)'(1);
            if (w_last) begin
              r_state  <= ST_PASS;
              r_done   <= 1'b1;
              r_passed <= 1'b1;
            end
          end else if (w_fail_code != FC_NONE) begin
            r_state     <= ST_FAIL;
            r_done      <= 1'b1;
            r_failed    <= 1'b1;
            r_fail_code <= w_fail_code;
            r_fail_idx  <= r_ptr;
            r_fail_obs  <= OUTPUT_PORT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign DONE      = r_done;
  assign PASSED    = r_passed;
  assign FAILED    = r_failed;
  assign FAIL_CODE = r_fail_code;
  assign FAIL_IDX  = r_fail_idx;
  assign FAIL_OBS  = r_fail_obs;
  assign PASS_CNT  = r_pass_cnt;
  assign CYCLE     = r_cycle;

endmodule

// File: tb/tb_riscv_test_checker.sv
// tb/tb_riscv_test_checker.sv - directed scoreboard bench for riscv_test_checker
module tb_riscv_test_checker;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        TBL_WE;
  logic [4:0]  TBL_ADDR;
  logic [31:0] TBL_NUM_INST;
  logic [31:0] TBL_ANS;
  logic        START;
  logic [31:0] NUM_INST;
  logic [31:0] OUTPUT_PORT;
  logic        HALT;
  logic        DONE;
  logic        PASSED;
  logic        FAILED;
  logic [1:0]  FAIL_CODE;
  logic [4:0]  FAIL_IDX;
  logic [31:0] FAIL_OBS;
  logic [5:0]  PASS_CNT;
  logic [31:0] CYCLE;

  riscv_test_checker #(.NUM_TEST(17), .IDX_W(5)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .TBL_WE       (TBL_WE),
    .TBL_ADDR     (TBL_ADDR),
    .TBL_NUM_INST (TBL_NUM_INST),
    .TBL_ANS      (TBL_ANS),
    .START        (START),
    .NUM_INST     (NUM_INST),
    .OUTPUT_PORT  (OUTPUT_PORT),
    .HALT         (HALT),
    .DONE         (DONE),
    .PASSED       (PASSED),
    .FAILED       (FAILED),
    .FAIL_CODE    (FAIL_CODE),
    .FAIL_IDX     (FAIL_IDX),
    .FAIL_OBS     (FAIL_OBS),
    .PASS_CNT     (PASS_CNT),
    .CYCLE        (CYCLE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        done;
    logic        passed;
    logic        failed;
    logic [1:0]  code;
    logic [4:0]  idx;
    logic [31:0] obs;
    logic [5:0]  pass_cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] tnum [17];
  logic [31:0] tans [17];
  int          n_checks = 0;
  int          n_err    = 0;
  int          run_cycles = 0;
  bit          running  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (running) run_cycles++;
  endtask

  task automatic push_exp(input logic done, input logic passed, input logic failed,
                          input logic [1:0] code, input logic [4:0] idx,
                          input logic [31:0] obs, input logic [5:0] pcnt);
    exp_t e;
    e.done = done; e.passed = passed; e.failed = failed;
    e.code = code; e.idx = idx; e.obs = obs; e.pass_cnt = pcnt;
    sb.push_back(e);
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".done"},     32'(DONE),      32'(e.done));
      chk({tag, ".passed"},   32'(PASSED),    32'(e.passed));
      chk({tag, ".failed"},   32'(FAILED),    32'(e.failed));
      chk({tag, ".code"},     32'(FAIL_CODE), 32'(e.code));
      chk({tag, ".idx"},      32'(FAIL_IDX),  32'(e.idx));
      chk({tag, ".obs"},      FAIL_OBS,       e.obs);
      chk({tag, ".pass_cnt"}, 32'(PASS_CNT),  32'(e.pass_cnt));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".done"},     32'(DONE),      32'd0);
    chk({tag, ".passed"},   32'(PASSED),    32'd0);
    chk({tag, ".failed"},   32'(FAILED),    32'd0);
    chk({tag, ".code"},     32'(FAIL_CODE), 32'd0);
    chk({tag, ".idx"},      32'(FAIL_IDX),  32'd0);
    chk({tag, ".obs"},      FAIL_OBS,       32'd0);
    chk({tag, ".pass_cnt"}, 32'(PASS_CNT),  32'd0);
    chk({tag, ".cycle"},    CYCLE,          32'd0);
  endtask

  task automatic async_reset(input string tag);
    #3;
    RSTn = 1'b0;
    #1;
    check_zero(tag);
    running = 0;
    step();
    RSTn = 1'b1;
    NUM_INST = 32'd0; OUTPUT_PORT = 32'd0; HALT = 1'b0;
  endtask

  task automatic do_start();
    START = 1'b1;
    step();
    START = 1'b0;
    running = 1;
    run_cycles = 0;
  endtask

  task automatic pass_entry(input int i, input string tag);
    NUM_INST = tnum[i];
    OUTPUT_PORT = tans[i];
    push_exp(i == 16, i == 16, 1'b0, 2'd0, 5'd0, 32'd0, 6'(i + 1));
    step();
    check_sb(tag);
  endtask

  task automatic verdict(input string tag);
    step();
    running = 0;
    check_sb(tag);
    chk({tag, ".cycle"}, CYCLE, 32'(run_cycles));
  endtask

  task automatic freeze_check(input string tag);
    logic [31:0] c;
    logic [5:0]  p;
    c = CYCLE;
    p = PASS_CNT;
    NUM_INST = 32'h7fff_0000; OUTPUT_PORT = 32'h5a5a_5a5a; HALT = 1'b1;
    repeat (3) step();
    HALT = 1'b0;
    chk({tag, ".cycle_frozen"}, CYCLE, c);
    chk({tag, ".pcnt_frozen"},  32'(PASS_CNT), 32'(p));
    chk({tag, ".done_held"},    32'(DONE), 32'd1);
  endtask

  initial begin
    tnum = '{32'h04, 32'h06, 32'h08, 32'h0a, 32'h0c, 32'h10, 32'h14, 32'h18, 32'h1c,
             32'h20, 32'h21, 32'h24, 32'h28, 32'h30, 32'h38, 32'h40, 32'h46};
    tans = '{32'h0eec, 32'h0001, 32'h0002, 32'h0f00, 32'h0ef0, 32'h1234, 32'h0055,
             32'hdead, 32'hbeef, 32'h0007, 32'h0abc, 32'h00ff, 32'h8000_0000,
             32'hffff_ffff, 32'h0100, 32'h0042, 32'h0};

    RSTn = 1'b0; TBL_WE = 1'b0; TBL_ADDR = '0; TBL_NUM_INST = '0; TBL_ANS = '0;
    START = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0; HALT = 1'b0;
    #1;
    check_zero("reset");
    step();
    step();
    RSTn = 1'b1;

    // Load the table; the final write shares its cycle with START.
    for (int i = 0; i < 17; i++) begin
      TBL_WE = 1'b1;
      TBL_ADDR = 5'(i);
      TBL_NUM_INST = tnum[i];
      TBL_ANS = tans[i];
      START = (i == 16);
      step();
    end
    TBL_WE = 1'b0;
    START = 1'b0;
    running = 1;
    run_cycles = 0;

    for (int i = 0; i < 16; i++) pass_entry(i, "full");
    NUM_INST = tnum[16]; OUTPUT_PORT = tans[16]; HALT = 1'b1;
    push_exp(1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 32'd0, 6'd17);
    verdict("full_pass");
    HALT = 1'b0;
    freeze_check("full_pass");

    // Value mismatch at entry 4; a table write during RUN must be ignored.
    async_reset("rst_a");
    do_start();
    TBL_WE = 1'b1; TBL_ADDR = 5'd0; TBL_NUM_INST = 32'h99; TBL_ANS = 32'h99;
    for (int i = 0; i < 4; i++) begin
      pass_entry(i, "mis");
      TBL_WE = 1'b0;
    end
    NUM_INST = 32'h0c; OUTPUT_PORT = 32'h0ef1;
    push_exp(1'b1, 1'b0, 1'b1, 2'd1, 5'd4, 32'h0ef1, 6'd4);
    verdict("mismatch");
    freeze_check("mismatch");

    // Skipped checkpoint: 0x20 -> 0x22 while entry 10 expects 0x21.
    async_reset("rst_b");
    do_start();
    for (int i = 0; i < 10; i++) pass_entry(i, "skp");
    NUM_INST = 32'h22; OUTPUT_PORT = 32'h0abc;
    push_exp(1'b1, 1'b0, 1'b1, 2'd2, 5'd10, 32'h0abc, 6'd10);
    verdict("skip");

    // Early halt after five passes.
    async_reset("rst_c");
    do_start();
    for (int i = 0; i < 5; i++) pass_entry(i, "hlt");
    NUM_INST = 32'h0d; OUTPUT_PORT = 32'h77; HALT = 1'b1;
    push_exp(1'b1, 1'b0, 1'b1, 2'd3, 5'd5, 32'h77, 6'd5);
    verdict("halt");
    HALT = 1'b0;

    // Held NUM_INST passes once; then reset mid-RUN and re-run the retained table.
    async_reset("rst_d");
    do_start();
    NUM_INST = tnum[0]; OUTPUT_PORT = tans[0];
    for (int k = 0; k < 3; k++) begin
      push_exp(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 6'd1);
      step();
      check_sb("hold");
    end
    async_reset("rst_midrun");
    do_start();
    for (int i = 0; i < 16; i++) pass_entry(i, "rerun");
    NUM_INST = tnum[16]; OUTPUT_PORT = tans[16];
    push_exp(1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 32'd0, 6'd17);
    verdict("rerun_pass");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_test_checker.md
RISCV_TEST_CHECKER -- requirements
Module: riscv_test_checker

Interface
REQ-001 Parameter NUM_TEST, default 17: number of checkpoint entries in the expected-result table.
REQ-002 Parameter IDX_W, default 5: index width; SHALL satisfy 2**IDX_W >= NUM_TEST.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 TBL_WE  input  1  table write strobe; honoured only in LOAD.
REQ-006 TBL_ADDR  input  IDX_W  table entry index being written.
REQ-007 TBL_NUM_INST  input  32  checkpoint instruction count for the written entry.
REQ-008 TBL_ANS  input  32  expected OUTPUT_PORT value for the written entry.
REQ-009 START  input  1  one-cycle pulse: LOAD -> RUN.
REQ-010 NUM_INST  input  32  retired-instruction count from RISCV_TOP.
REQ-011 OUTPUT_PORT  input  32  core output port from RISCV_TOP.
REQ-012 HALT  input  1  core halt indication from RISCV_TOP.
REQ-013 DONE  output  1  high in PASS or FAIL.
REQ-014 PASSED  output  1  high in PASS.
REQ-015 FAILED  output  1  high in FAIL.
REQ-016 FAIL_CODE  output  2  0 none, 1 value mismatch, 2 checkpoint skipped, 3 halt before all checkpoints.
REQ-017 FAIL_IDX  output  IDX_W  index of the failing entry.
REQ-018 FAIL_OBS  output  32  OUTPUT_PORT value captured at failure.
REQ-019 PASS_CNT  output  IDX_W+1  number of checkpoints passed.
REQ-020 CYCLE  output  32  RUN-state cycle count, saturating at 0xFFFF_FFFF.

Function
REQ-021 The FSM SHALL have states LOAD, RUN, PASS and FAIL; PASS and FAIL are terminal until reset.
REQ-022 In LOAD, TBL_WE=1 with TBL_ADDR < NUM_TEST SHALL write {TBL_NUM_INST, TBL_ANS} to that entry in the same edge; addresses >= NUM_TEST are ignored.
REQ-023 In LOAD, START=1 SHALL enter RUN on the next edge with ptr=0; TBL_WE and START asserted in the same cycle SHALL perform the write and then the transition.
REQ-024 In RUN, CYCLE SHALL increment once per cycle, starting from 0.
REQ-025 In RUN, each cycle the block SHALL compare NUM_INST with entry[ptr].num_inst; only entry[ptr] is examined.
REQ-026 If NUM_INST equals entry[ptr].num_inst and OUTPUT_PORT equals entry[ptr].ans, PASS_CNT and ptr SHALL both increment on the next edge.
REQ-027 If that passing entry has ptr = NUM_TEST-1, the next state SHALL be PASS.
REQ-028 If NUM_INST equals entry[ptr].num_inst but OUTPUT_PORT differs from entry[ptr].ans, the next state SHALL be FAIL with FAIL_CODE=1, FAIL_IDX=ptr and FAIL_OBS=OUTPUT_PORT.
REQ-029 If NUM_INST is greater than entry[ptr].num_inst (unsigned), the next state SHALL be FAIL with FAIL_CODE=2, FAIL_IDX=ptr and FAIL_OBS=OUTPUT_PORT.
REQ-030 HALT=1 in RUN with no checkpoint matching in that cycle SHALL enter FAIL with FAIL_CODE=3 and FAIL_IDX=ptr.
REQ-031 HALT=1 coinciding with a match on the last entry SHALL enter PASS; HALT coinciding with a mismatch or skip SHALL report that mismatch or skip code.
REQ-032 After an entry passes, a NUM_INST value held for several cycles SHALL NOT re-trigger that entry.
REQ-033 The table SHALL be loaded with strictly increasing num_inst values; a duplicate value causes the following entry to be evaluated on the next cycle.
REQ-034 CYCLE, PASS_CNT and the FAIL_* outputs SHALL freeze in PASS and FAIL.
REQ-035 All outputs SHALL be registered; every verdict appears one cycle after the triggering inputs.

Reset
REQ-036 RSTn low SHALL immediately force LOAD, ptr=0, DONE=0, PASSED=0, FAILED=0, FAIL_CODE=0, FAIL_IDX=0, FAIL_OBS=0, PASS_CNT=0 and CYCLE=0, including mid-RUN.
REQ-037 Table contents SHALL NOT be reset; a re-run after reset needs only START.

Structure
REQ-038 A shared package riscv_tb_pkg SHALL hold the state encoding, the FAIL_CODE constants and the default NUM_TEST.
REQ-039 The table SHALL be a sub-module chk_table: NUM_TEST x 64-bit register array, one write port and one combinational read port.

Verification
REQ-040 Load the 17-entry table (4/0x0eec … 0x46/0); drive matching NUM_INST/OUTPUT_PORT, then HALT -> PASSED=1, PASS_CNT=17, FAIL_CODE=0.
REQ-041 At NUM_INST=0x0c drive OUTPUT_PORT=0x0ef1 -> FAILED=1, FAIL_CODE=1, FAIL_IDX=4, FAIL_OBS=0x0ef1.
REQ-042 Jump NUM_INST from 0x20 to 0x22 (entry 10 expects 0x21) -> FAIL_CODE=2, FAIL_IDX=10.
REQ-043 Assert HALT after 5 passes -> FAIL_CODE=3, FAIL_IDX=5, PASS_CNT=5.
REQ-044 Hold NUM_INST=4 for 3 cycles -> PASS_CNT=1, not 3; deassert RSTn mid-RUN -> all outputs return to 0 asynchronously, and START re-runs on the retained table.
